// File: rtl/i2c_rx_fifo.sv
// i2c_rx_fifo
//   Receive-side byte buffer behind the I2C master/slave receive path. Each rising edge of
//   rx_data_enable captures rx_data into a first-word-fall-through FIFO. The host reads the
//   FIFO over a valid/ready interface. Sticky flags record dropped bytes and bus errors.
//
// Parameters
//   ADDR_W          FIFO address width; depth = 2**ADDR_W (ADDR_W >= 1)
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   rx_data         received byte (data_receive_master / data_receive_slave)
//   rx_data_enable  byte-valid level; one push per rising edge
//   rx_error        error level from the I2C block; rising edge sets err_flag
//   rd_data         byte at FIFO head, 8'h00 when empty
//   rd_valid        FIFO non-empty
//   rd_ready        host accepts rd_data when rd_valid & rd_ready
//   count           bytes stored, 0..2**ADDR_W
//   full, empty     FIFO status
//   overflow        sticky: a byte was dropped because the FIFO was full
//   err_flag        sticky: rising edge of rx_error seen
//   clr_flags       clears overflow and err_flag; a same-cycle set event wins
//
// Configuration
//   I2C_RX_ERR_FLUSH_EN  when defined, an rx_error rising edge also empties the FIFO and
//                        discards any push or pop in that cycle.

module i2c_rx_fifo #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_enable,
    input  logic              rx_error,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              err_flag,
    input  logic              clr_flags
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        mem_q [Depth];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              en_prev_q, err_prev_q;
    logic              overflow_q, overflow_d;
    logic              err_flag_q, err_flag_d;

    logic push, pop, err_rise, flush;
    logic do_push, do_pop, drop;

    assign push     = rx_data_enable & ~en_prev_q;
    assign err_rise = rx_error & ~err_prev_q;

`ifdef I2C_RX_ERR_FLUSH_EN
    assign flush = err_rise;
`else
    assign flush = 1'b0;
`endif

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign count    = count_q;
    assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign err_flag = err_flag_q;

    assign pop = rd_valid & rd_ready;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        do_push = push & (~full | pop) & ~flush;
        do_pop  = pop & ~flush;
        drop    = push & full & ~pop & ~flush;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_flag_d = err_flag_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end

        // Clear first so a concurrent set event takes precedence.
        if (clr_flags) begin
            overflow_d = 1'b0;
            err_flag_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (err_rise) begin
            err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_flag_q <= 1'b0;
            // Start high so a level already asserted at reset release is not taken as an edge.
            en_prev_q  <= 1'b1;
            err_prev_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_flag_q <= err_flag_d;
            en_prev_q  <= rx_data_enable;
            err_prev_q <= rx_error;
        end
    end

    // Storage is not reset; only written entries are ever read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_i2c_rx_fifo.sv
module tb_i2c_rx_fifo;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_data_enable;
    logic          rx_error;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          err_flag;
    logic          clr_flags;

    i2c_rx_fifo #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_data_enable (rx_data_enable),
        .rx_error       (rx_error),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .err_flag       (err_flag),
        .clr_flags      (clr_flags)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_err = 0;
    logic [7:0] sb_q[$];
    logic      exp_ovf = 1'b0;
    logic      exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        logic [7:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : 8'h00;
        check_eq({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        check_eq({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(sb_q.size() == DEPTH));
        check_eq({tag, ".valid"}, 32'(rd_valid), 32'(sb_q.size() != 0));
        check_eq({tag, ".data"}, 32'(rd_data), 32'(head));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check_eq({tag, ".err"}, 32'(err_flag), 32'(exp_err));
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data        = b;
        rx_data_enable = 1'b1;
        if (sb_q.size() < DEPTH) sb_q.push_back(b);
        else exp_ovf = 1'b1;
        tick();
        rx_data_enable = 1'b0;
        tick();
    endtask

    // Pops one entry per cycle until the scoreboard is empty.
    task automatic drain(input string tag);
        int n;
        n = sb_q.size();
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_eq({tag, ".rvalid"}, 32'(rd_valid), 32'd1);
            check_eq({tag, ".rdata"}, 32'(rd_data), 32'(sb_q.pop_front()));
            tick();
        end
        rd_ready = 1'b0;
        check_status({tag, ".end"});
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_data_enable = 1'b0; rx_error = 1'b0;
        rd_ready = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_status("reset");
        rst = 1'b0;
        tick();

        // Basic ordering
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        check_status("three");
        drain("three");

        // Held enable yields a single push
        rx_data = 8'h11;
        rx_data_enable = 1'b1;
        sb_q.push_back(8'h11);
        for (int i = 0; i < 5; i++) tick();
        rx_data_enable = 1'b0;
        tick();
        check_status("held");
        drain("held");

        // Overflow: 17 bytes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check_status("ovf");
        clr_flags = 1'b1;
        exp_ovf = 1'b0;
        tick();
        clr_flags = 1'b0;
        check_status("clr");

        // Full with simultaneous push and pop
        rx_data = 8'h77;
        rx_data_enable = 1'b1;
        rd_ready = 1'b1;
        check_eq("fullpp.rdata", 32'(rd_data), 32'(sb_q.pop_front()));
        sb_q.push_back(8'h77);
        tick();
        rx_data_enable = 1'b0;
        rd_ready = 1'b0;
        tick();
        check_status("fullpp");
        drain("fullpp");

        // Error edge with three bytes queued
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        rx_error = 1'b1;
        exp_err = 1'b1;
`ifdef I2C_RX_ERR_FLUSH_EN
        sb_q.delete();
`endif
        tick();
        rx_error = 1'b0;
        tick();
        check_status("err");
        clr_flags = 1'b1;
        rx_error = 1'b1;
        tick();
        clr_flags = 1'b0;
        rx_error = 1'b0;
        tick();
        check_status("errclr");
        clr_flags = 1'b1;
        exp_err = 1'b0;
        tick();
        clr_flags = 1'b0;
        check_status("clronly");
        drain("err");

        // Enable held high through reset release
        rx_data = 8'h55;
        rx_data_enable = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_status("rstheld");
        rx_data_enable = 1'b0;
        tick();
        check_status("rstlow");
        rx_data_enable = 1'b1;
        sb_q.push_back(8'h55);
        tick();
        rx_data_enable = 1'b0;
        check_status("rstrepush");
        drain("rstrepush");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
